// File: rtl/zap_wb_ram_slave.sv
// Wishbone B3 registered-feedback RAM responder: classic, incrementing-burst and
// end-of-burst cycles with a programmable number of wait states before the first ack.
`timescale 1ns/1ps
module zap_wb_ram_slave #(
    parameter int unsigned DEPTH       = 32'd4096,
    parameter int unsigned WAIT_STATES = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CTI_BURST = 3'b010;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        BURST = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [29:0] idx, idx_nxt;
    logic        ack_nxt, err_nxt;
    logic        req;
    logic [29:0] adr_idx;
    logic        wr_en;
    logic        unused_adr;

    logic [31:0] mem [0:DEPTH-1];

    function automatic logic in_range(input logic [29:0] i);
        return {2'b00, i} < DEPTH;
    endfunction

    assign req        = i_wb_cyc & i_wb_stb;
    assign adr_idx    = i_wb_adr[31:2];
    assign unused_adr = ^i_wb_adr[1:0];

    // Each ack/err is decided one cycle ahead, so the outputs are plain flops.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    idx_nxt = adr_idx;
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        ack_nxt   = in_range(adr_idx);
                        err_nxt   = !in_range(adr_idx);
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    ack_nxt   = in_range(idx);
                    err_nxt   = !in_range(idx);
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP, BURST: begin
                // The strobe seen here belongs to the beat being acked; only a
                // successful beat tagged as incrementing burst chains onward.
                state_nxt = IDLE;
                if (req && o_wb_ack && i_wb_cti == CTI_BURST) begin
                    idx_nxt   = idx + 30'd1;
                    state_nxt = BURST;
                    ack_nxt   = in_range(idx + 30'd1);
                    err_nxt   = !in_range(idx + 30'd1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx      <= 30'd0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            o_wb_ack <= ack_nxt;
            o_wb_err <= err_nxt;
            o_wb_dat <= ack_nxt ? mem[idx_nxt[AW-1:0]] : 32'd0;
        end
    end

    // Writes land at the end of the ack cycle using whatever the master presents then.
    assign wr_en = !i_reset && o_wb_ack && req && i_wb_wen && in_range(adr_idx);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    mem[adr_idx[AW-1:0]][8*b +: 8] <= i_wb_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_zap_wb_ram_slave.sv
// Directed bench for zap_wb_ram_slave: a WAIT_STATES=2 instance drives most scenarios,
// a WAIT_STATES=3 instance on the same bus covers the aborted-wait case.
`timescale 1ns/1ps
module tb_zap_wb_ram_slave;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, wen = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic [2:0]  cti = 3'b000;
    logic [31:0] dat, dat3;
    logic        ack, err, ack3, err3;

    int total = 0;
    int pass  = 0;

    always #5 clk = ~clk;

    zap_wb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_wen(wen),
        .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
        .o_wb_dat(dat), .o_wb_ack(ack), .o_wb_err(err)
    );

    zap_wb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_wen(wen),
        .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
        .o_wb_dat(dat3), .o_wb_ack(ack3), .o_wb_err(err3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Tick until the selected instance answers; lat stays 0 on timeout.
    task automatic wait_resp(input bit use3, output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (use3 ? (ack3 | err3) : (ack | err)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic classic(input bit use3, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic [31:0] rd,
                           output logic e, output logic single);
        cyc = 1'b1; stb = 1'b1; wen = we; adr = a; wdat = d; sel = s; cti = 3'b000;
        wait_resp(use3, lat);
        rd = use3 ? dat3 : dat;
        e  = use3 ? err3 : err;
        tick;
        single = use3 ? !(ack3 | err3) : !(ack | err);
        cyc = 1'b0; stb = 1'b0; wen = 1'b0;
    endtask

    task automatic wr(input bit use3, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int l; logic [31:0] r; logic e, sg;
        classic(use3, 1'b1, a, d, s, l, r, e, sg);
    endtask

    task automatic rd(input bit use3, input logic [31:0] a, output logic [31:0] r);
        int l; logic e, sg;
        classic(use3, 1'b0, a, 32'd0, 4'h0, l, r, e, sg);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        total++; if (ack !== 1'b0) $display("FAIL rst_ack got %b want 0", ack); else pass++;
        total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else pass++;
        total++; if (dat !== 32'd0) $display("FAIL rst_dat got %h want 0", dat); else pass++;
        total++; if ((ack3 | err3) !== 1'b0) $display("FAIL rst_ack3 got %b want 0", ack3 | err3); else pass++;
        rst = 1'b0;
    endtask

    task automatic test_classic_read;
        int l; logic [31:0] r; logic e, sg;
        classic(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, l, r, e, sg);
        total++; if (l != 3 || e !== 1'b0) $display("FAIL cl_wr_lat got %0d err %b want 3 err 0", l, e); else pass++;
        classic(0, 1'b0, 32'h10, 32'd0, 4'h0, l, r, e, sg);
        total++; if (l != 3) $display("FAIL cl_rd_lat got %0d want 3", l); else pass++;
        total++; if (r !== 32'hDEADBEEF) $display("FAIL cl_rd_dat got %h want deadbeef", r); else pass++;
        total++; if (sg !== 1'b1 || e !== 1'b0) $display("FAIL cl_rd_single got %b err %b want 1 0", sg, e); else pass++;
    endtask

    task automatic test_byte_lanes;
        int l; logic [31:0] r; logic e, sg;
        wr(0, 32'h20, 32'hAAAAAAAA, 4'hF);
        wr(0, 32'h20, 32'h11223344, 4'b0101);
        rd(0, 32'h20, r);
        total++; if (r !== 32'hAA22AA44) $display("FAIL sel0101 got %h want aa22aa44", r); else pass++;
        classic(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, l, r, e, sg);
        total++; if (l != 3 || e !== 1'b0) $display("FAIL sel0000_ack got lat %0d err %b want 3 0", l, e); else pass++;
        rd(0, 32'h20, r);
        total++; if (r !== 32'hAA22AA44) $display("FAIL sel0000_keep got %h want aa22aa44", r); else pass++;
    endtask

    task automatic test_back_to_back;
        int l, n;
        cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = 32'h10; cti = 3'b000;
        wait_resp(0, l);
        total++; if (dat !== 32'hDEADBEEF) $display("FAIL b2b_first got %h want deadbeef", dat); else pass++;
        tick;
        adr = 32'h20;
        n = 0;
        wait_resp(0, n);
        total++; if (n + 1 != 4) $display("FAIL b2b_period got %0d want 4", n + 1); else pass++;
        total++; if (dat !== 32'hAA22AA44) $display("FAIL b2b_second got %h want aa22aa44", dat); else pass++;
        tick;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_burst_read;
        int l;
        for (int i = 0; i < 4; i++) wr(0, 32'h40 + 32'(4 * i), 32'hC0DE0010 + 32'(i), 4'hF);
        cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = 32'h40; cti = 3'b010;
        wait_resp(0, l);
        total++; if (l != 3) $display("FAIL br_lat got %0d want 3", l); else pass++;
        total++; if (ack !== 1'b1 || dat !== 32'hC0DE0010) $display("FAIL br_beat0 got ack %b dat %h want 1 c0de0010", ack, dat); else pass++;
        for (int b = 1; b < 4; b++) begin
            tick;
            adr = 32'h40 + 32'(4 * b);
            cti = (b == 3) ? 3'b111 : 3'b010;
            total++;
            if (ack !== 1'b1 || dat !== 32'hC0DE0010 + 32'(b))
                $display("FAIL br_beat%0d got ack %b dat %h want 1 %h", b, ack, dat, 32'hC0DE0010 + 32'(b));
            else pass++;
        end
        tick;
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        total++; if ((ack | err) !== 1'b0) $display("FAIL br_end got %b want 0", ack | err); else pass++;
    endtask

    task automatic test_burst_top;
        int l; logic [31:0] r; logic e, sg;
        wr(0, 32'h0, 32'h0BADC0DE, 4'hF);
        cyc = 1'b1; stb = 1'b1; wen = 1'b1; sel = 4'hF; adr = DEPTH * 4 - 4; wdat = 32'hCAFEF00D; cti = 3'b010;
        wait_resp(0, l);
        total++; if (ack !== 1'b1 || err !== 1'b0) $display("FAIL top_beat0 got ack %b err %b want 1 0", ack, err); else pass++;
        tick;
        adr = DEPTH * 4; wdat = 32'h12345678; cti = 3'b111;
        total++; if (err !== 1'b1 || ack !== 1'b0) $display("FAIL top_beat1 got err %b ack %b want 1 0", err, ack); else pass++;
        total++; if (dat !== 32'd0) $display("FAIL top_errdat got %h want 0", dat); else pass++;
        tick;
        cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = 3'b000;
        total++; if ((ack | err) !== 1'b0) $display("FAIL top_end got %b want 0", ack | err); else pass++;
        rd(0, DEPTH * 4 - 4, r);
        total++; if (r !== 32'hCAFEF00D) $display("FAIL top_written got %h want cafef00d", r); else pass++;
        rd(0, 32'h0, r);
        total++; if (r !== 32'h0BADC0DE) $display("FAIL top_nowrap got %h want 0badc0de", r); else pass++;
        classic(0, 1'b0, DEPTH * 4, 32'd0, 4'h0, l, r, e, sg);
        total++; if (e !== 1'b1 || r !== 32'd0 || l != 3) $display("FAIL oor_read got err %b dat %h lat %0d want 1 0 3", e, r, l); else pass++;
    endtask

    task automatic test_reset_mid_burst;
        int l; logic [31:0] r;
        wr(0, 32'h60, 32'h0, 4'hF);
        wr(0, 32'h64, 32'h55555555, 4'hF);
        cyc = 1'b1; stb = 1'b1; wen = 1'b1; sel = 4'hF; adr = 32'h60; wdat = 32'hA5A5A5A5; cti = 3'b010;
        wait_resp(0, l);
        tick;
        adr = 32'h64; wdat = 32'h5A5A5A5A;
        total++; if (ack !== 1'b1) $display("FAIL rmb_beat1 got %b want 1", ack); else pass++;
        rst = 1'b1;
        tick;
        total++; if ((ack | err) !== 1'b0) $display("FAIL rmb_ack got %b want 0", ack | err); else pass++;
        cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = 3'b000; rst = 1'b0;
        tick;
        rd(0, 32'h60, r);
        total++; if (r !== 32'hA5A5A5A5) $display("FAIL rmb_beat0_kept got %h want a5a5a5a5", r); else pass++;
        rd(0, 32'h64, r);
        total++; if (r !== 32'h55555555) $display("FAIL rmb_beat1_dropped got %h want 55555555", r); else pass++;
    endtask

    task automatic test_abort_wait;
        int l, seen; logic [31:0] r; logic e, sg;
        rst = 1'b1; tick; tick; rst = 1'b0;
        cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = 32'h10; cti = 3'b000;
        tick; tick;
        cyc = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            stb = 1'b0;
            if ((ack | err | ack3 | err3) !== 1'b0) seen++;
        end
        total++; if (seen != 0) $display("FAIL abort_noack got %0d responses want 0", seen); else pass++;
        wr(1, 32'h30, 32'h3C3C3C3C, 4'hF);
        classic(1, 1'b0, 32'h30, 32'd0, 4'h0, l, r, e, sg);
        total++; if (l != 4) $display("FAIL abort_next_lat got %0d want 4", l); else pass++;
        total++; if (r !== 32'h3C3C3C3C || e !== 1'b0 || sg !== 1'b1)
            $display("FAIL abort_next_rd got %h err %b single %b want 3c3c3c3c 0 1", r, e, sg);
        else pass++;
    endtask

    initial begin
        test_reset;
        test_classic_read;
        test_byte_lanes;
        test_back_to_back;
        test_burst_read;
        test_burst_top;
        test_reset_mid_burst;
        test_abort_wait;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
